// File: rtl/sdad_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM state
// encoding and the byte width of the UART transmitter.
package sdad_pkg;

  localparam int C_UART_DATA_WIDTH = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: starting one position after ptr and wrapping, the
// first asserted request wins. Purely combinational.
module rr_pick #(
  parameter int C_REQ   = 4,
  parameter int C_IDX_W = 2
) (
  input  logic [C_REQ-1:0]   req,
  input  logic [C_IDX_W-1:0] ptr,
  output logic [C_REQ-1:0]   grant,
  output logic [C_IDX_W-1:0] idx
);

  // Walk the requesters in priority order and keep the first one found
  always_comb begin
    logic found;
    int   cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= C_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= C_REQ) cand = cand - C_REQ;
      if (!found && req[C_IDX_W'(cand)]) begin
        found = 1'b1;
        grant[C_IDX_W'(cand)] = 1'b1;
        idx   = C_IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level arbiter in front of a single UART transmitter. A requester
// owns the transmitter from its first byte until its last byte, so bytes of
// different frames never interleave. Owners are chosen round-robin.
// Optional feature macro: UART_ARB_TIMEOUT_EN releases a lock whose owner
// has stalled for C_TIMEOUT cycles and pulses oTimeout.
module uart_tx_arbiter
  import sdad_pkg::*;
#(
  parameter int C_REQ        = 4,
  parameter int C_DATA_WIDTH = C_UART_DATA_WIDTH,
  parameter int C_TIMEOUT    = 1000000
) (
  input  logic                          sysClk,
  input  logic                          sysRst,
  input  logic [C_REQ-1:0]              iReqValid,
  input  logic [C_REQ*C_DATA_WIDTH-1:0] iReqData,
  input  logic [C_REQ-1:0]              iReqLast,
  output logic [C_REQ-1:0]              oReqReady,
  output logic [C_DATA_WIDTH-1:0]       oTxData,
  output logic                          oTxValid,
  input  logic                          iTxReady,
  output logic [C_REQ-1:0]              oGrant,
  output logic                          oTimeout
);

  localparam int IDX_W = $clog2(C_REQ);

  logic [0:0]              state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        owner_idx;
  logic [C_REQ-1:0]        owner_oh;
  logic [C_REQ-1:0]        pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic [C_DATA_WIDTH-1:0] tx_data;
  logic                    tx_valid;
  logic                    owner_valid;
  logic                    owner_last;
  logic                    owner_ready;
  logic                    accept;
  logic                    stall_expire;
  logic [C_DATA_WIDTH-1:0] owner_byte;

  rr_pick #(
    .C_REQ   (C_REQ),
    .C_IDX_W (IDX_W)
  ) u_pick (
    .req   (iReqValid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Owner's view of the handshake; ready is held off during reset so no byte is taken
  always_comb begin
    owner_valid = |(iReqValid & owner_oh);
    owner_last  = |(iReqLast & owner_oh);
    owner_byte  = iReqData[owner_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
    owner_ready = (state == ST_LOCK) && !sysRst && (!tx_valid || iTxReady);
    accept      = owner_ready && owner_valid;
  end

  assign oReqReady = owner_ready ? owner_oh : '0;
  assign oGrant    = ((state == ST_LOCK) && !sysRst) ? owner_oh : '0;
  assign oTxData   = tx_data;
  assign oTxValid  = tx_valid;

  // Arbitration FSM: pick an owner when idle, release on last byte or stall expiry
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state     <= ST_IDLE;
      ptr       <= IDX_W'(C_REQ - 1);
      owner_idx <= '0;
      owner_oh  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|iReqValid) begin
            owner_idx <= pick_idx;
            owner_oh  <= pick_grant;
            state     <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if ((accept && owner_last) || stall_expire) begin
            ptr   <= owner_idx;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output byte register: load on acceptance, hold until the transmitter takes it
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (accept) begin
      tx_data  <= owner_byte;
      tx_valid <= 1'b1;
    end else if (iTxReady) begin
      tx_valid <= 1'b0;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(C_TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_q;

  assign stall_expire = (state == ST_LOCK) && !owner_valid &&
                        (stall_cnt == CNT_W'(C_TIMEOUT - 1));
  assign oTimeout     = timeout_q;

  // Count consecutive locked cycles with the owner silent; any owner activity restarts it
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_expire;
      if ((state != ST_LOCK) || owner_valid || stall_expire) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  // Lock is never released by stalling; the comparison folds to constant 0
  assign stall_expire = (C_TIMEOUT < 0);
  assign oTimeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (4 requesters, 8-bit bytes).
// Expected bytes and grants go into scoreboard queues when frames are
// loaded; the monitor pops and compares them as the DUT produces them.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              sysClk = 1'b0;
  logic              sysRst;
  logic [NREQ-1:0]   iReqValid;
  logic [NREQ*W-1:0] iReqData;
  logic [NREQ-1:0]   iReqLast;
  logic [NREQ-1:0]   oReqReady;
  logic [W-1:0]      oTxData;
  logic              oTxValid;
  logic              iTxReady;
  logic [NREQ-1:0]   oGrant;
  logic              oTimeout;

  logic [8:0]      reqQ [NREQ][$];
  logic [7:0]      expData[$];
  logic [3:0]      expGrant[$];
  logic [NREQ-1:0] prevGrant;
  int testsRun    = 0;
  int testsFailed = 0;
  int popped      = 0;
  int timeoutPulses = 0;
  int runLen = 0;
  int maxRun = 0;

  always #5 sysClk = ~sysClk;

  uart_tx_arbiter #(
    .C_REQ        (NREQ),
    .C_DATA_WIDTH (W),
    .C_TIMEOUT    (16)
  ) dut (
    .sysClk    (sysClk),
    .sysRst    (sysRst),
    .iReqValid (iReqValid),
    .iReqData  (iReqData),
    .iReqLast  (iReqLast),
    .oReqReady (oReqReady),
    .oTxData   (oTxData),
    .oTxValid  (oTxValid),
    .iTxReady  (iTxReady),
    .oGrant    (oGrant),
    .oTimeout  (oTimeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic driveInputs();
    for (int k = 0; k < NREQ; k++) begin
      if (reqQ[k].size() > 0) begin
        iReqValid[k]       = 1'b1;
        iReqLast[k]        = reqQ[k][0][8];
        iReqData[k*W +: W] = reqQ[k][0][7:0];
      end else begin
        iReqValid[k]       = 1'b0;
        iReqLast[k]        = 1'b0;
        iReqData[k*W +: W] = '0;
      end
    end
  endtask

  // One clock: sample at negedge, retire handshakes after posedge, redrive
  task automatic applyStimulus(input int n);
    logic [NREQ-1:0] fireMask;
    for (int c = 0; c < n; c++) begin
      @(negedge sysClk);
      fireMask = iReqValid & oReqReady;
      if (oTxValid && iTxReady) begin
        if (expData.size() == 0) begin
          checkOutput("tx_unexpected", {31'b0, oTxValid}, 32'd0);
        end else begin
          checkOutput("tx_data", {24'b0, oTxData}, {24'b0, expData.pop_front()});
        end
        popped++;
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
      end else begin
        runLen = 0;
      end
      if ((oGrant != '0) && (prevGrant == '0)) begin
        if (expGrant.size() == 0) checkOutput("grant_unexpected", {28'b0, oGrant}, 32'd0);
        else checkOutput("grant_order", {28'b0, oGrant}, {28'b0, expGrant.pop_front()});
      end
      prevGrant = oGrant;
      if (oTimeout) timeoutPulses++;
      @(posedge sysClk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (fireMask[k] && reqQ[k].size() > 0) void'(reqQ[k].pop_front());
      end
      driveInputs();
    end
  endtask

  task automatic waitPopped(input int target, input int budget, input string tag);
    int c = 0;
    while (popped < target && c < budget) begin
      applyStimulus(1);
      c++;
    end
    checkOutput(tag, popped, target);
  endtask

  task automatic doReset();
    sysRst   = 1'b1;
    iTxReady = 1'b0;
    for (int k = 0; k < NREQ; k++) reqQ[k].delete();
    driveInputs();
    applyStimulus(2);
    sysRst = 1'b0;
  endtask

  task automatic endTest(input string tag);
    checkOutput({tag, "_data_left"}, expData.size(), 0);
    checkOutput({tag, "_grant_left"}, expGrant.size(), 0);
    expData.delete();
    expGrant.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    prevGrant = '0;
    iReqValid = '0;
    iReqLast  = '0;
    iReqData  = '0;

    // Reset state, sampled while reset is still asserted
    sysRst   = 1'b1;
    iTxReady = 1'b0;
    applyStimulus(2);
    #1;
    checkOutput("rst_txvalid", {31'b0, oTxValid}, 32'd0);
    checkOutput("rst_txdata", {24'b0, oTxData}, 32'd0);
    checkOutput("rst_grant", {28'b0, oGrant}, 32'd0);
    checkOutput("rst_ready", {28'b0, oReqReady}, 32'd0);
    checkOutput("rst_timeout", {31'b0, oTimeout}, 32'd0);
    sysRst = 1'b0;

    // Single requester, 3-byte frame
    iTxReady = 1'b1;
    maxRun   = 0;
    reqQ[1].push_back({1'b0, 8'h41});
    reqQ[1].push_back({1'b0, 8'h42});
    reqQ[1].push_back({1'b1, 8'h43});
    expData.push_back(8'h41); expData.push_back(8'h42); expData.push_back(8'h43);
    expGrant.push_back(4'b0010);
    driveInputs();
    waitPopped(popped + 3, 20, "single_wait");
    checkOutput("single_consecutive", maxRun, 3);
    applyStimulus(2);
    #1;
    checkOutput("single_idle_grant", {28'b0, oGrant}, 32'd0);
    endTest("single");

    // Fairness: all requesters with two back-to-back 2-byte frames
    doReset();
    iTxReady = 1'b1;
    for (int k = 0; k < NREQ; k++)
      for (int f = 0; f < 2; f++)
        for (int b = 0; b < 2; b++)
          reqQ[k].push_back({(b == 1), 8'(k*16 + f*2 + b)});
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < NREQ; k++) begin
        expGrant.push_back(4'(1 << k));
        for (int b = 0; b < 2; b++) expData.push_back(8'(k*16 + f*2 + b));
      end
    driveInputs();
    waitPopped(popped + 16, 200, "fair_wait");
    endTest("fair");

    // Backpressure: transmitter stalls 20 cycles with a byte pending
    doReset();
    iTxReady = 1'b0;
    for (int b = 0; b < 4; b++) begin
      reqQ[0].push_back({(b == 3), 8'(8'h10 + b)});
      expData.push_back(8'(8'h10 + b));
    end
    expGrant.push_back(4'b0001);
    driveInputs();
    applyStimulus(4);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1);
      #1;
      checkOutput("bp_data", {24'b0, oTxData}, 32'h10);
      checkOutput("bp_valid", {31'b0, oTxValid}, 32'd1);
      checkOutput("bp_ready", {31'b0, oReqReady[0]}, 32'd0);
    end
    iTxReady = 1'b1;
    waitPopped(popped + 4, 30, "bp_wait");
    endTest("bp");

`ifdef UART_ARB_TIMEOUT_EN
    // Owner stalls past the timeout; next valid requester takes over
    doReset();
    iTxReady = 1'b1;
    timeoutPulses = 0;
    base = popped;
    reqQ[0].push_back({1'b0, 8'h20});
    reqQ[2].push_back({1'b0, 8'h30});
    reqQ[2].push_back({1'b1, 8'h31});
    expData.push_back(8'h20); expData.push_back(8'h30); expData.push_back(8'h31);
    expGrant.push_back(4'b0001); expGrant.push_back(4'b0100);
    driveInputs();
    applyStimulus(40);
    checkOutput("to_pulses", timeoutPulses, 1);
    checkOutput("to_popped", popped, base + 3);
    endTest("to");
`else
    // Owner goes quiet mid-frame for 50+ cycles; lock must hold
    doReset();
    iTxReady = 1'b1;
    base = popped;
    reqQ[0].push_back({1'b0, 8'h20});
    reqQ[2].push_back({1'b0, 8'h30});
    reqQ[2].push_back({1'b1, 8'h31});
    expData.push_back(8'h20); expData.push_back(8'h21); expData.push_back(8'h22);
    expData.push_back(8'h30); expData.push_back(8'h31);
    expGrant.push_back(4'b0001); expGrant.push_back(4'b0100);
    driveInputs();
    applyStimulus(55);
    #1;
    checkOutput("stall_grant", {28'b0, oGrant}, 32'h1);
    checkOutput("stall_popped", popped, base + 1);
    checkOutput("stall_timeout", {31'b0, oTimeout}, 32'd0);
    reqQ[0].push_back({1'b0, 8'h21});
    reqQ[0].push_back({1'b1, 8'h22});
    driveInputs();
    waitPopped(base + 5, 40, "stall_wait");
    endTest("stall");
`endif

    // Reset mid-frame after the second of four bytes
    doReset();
    iTxReady = 1'b1;
    reqQ[0].push_back({1'b0, 8'h50});
    reqQ[0].push_back({1'b0, 8'h51});
    reqQ[0].push_back({1'b0, 8'h52});
    reqQ[0].push_back({1'b1, 8'h53});
    expData.push_back(8'h50); expData.push_back(8'h51);
    expGrant.push_back(4'b0001);
    driveInputs();
    waitPopped(popped + 2, 20, "mrst_wait");
    sysRst   = 1'b1;
    iTxReady = 1'b0;
    for (int k = 0; k < NREQ; k++) reqQ[k].delete();
    driveInputs();
    applyStimulus(1);
    #1;
    checkOutput("mrst_txvalid", {31'b0, oTxValid}, 32'd0);
    checkOutput("mrst_grant", {28'b0, oGrant}, 32'd0);
    checkOutput("mrst_txdata", {24'b0, oTxData}, 32'd0);
    sysRst   = 1'b0;
    iTxReady = 1'b1;
    reqQ[1].push_back({1'b1, 8'h61});
    reqQ[0].push_back({1'b1, 8'h60});
    expData.push_back(8'h60); expData.push_back(8'h61);
    expGrant.push_back(4'b0001); expGrant.push_back(4'b0010);
    driveInputs();
    waitPopped(popped + 2, 20, "mrst_after_wait");
    endTest("mrst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
